codificador_nota_evento: RTL and testbench
==========================================

CODIFICADOR_NOTA_EVENTO -- requirements
Module: codificador_nota_evento

Interface
REQ-001 Parameter NUM_NOTAS, default 12: width of one-hot note input; legal range 2..64.
REQ-002 Parameter VALOR_W, default 4: width of binary note index; SHALL equal ceil(log2(NUM_NOTAS)).
REQ-003 Parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a press; legal range 1..255.
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  block enable; low forces idle.
REQ-007 nota  input  NUM_NOTAS  one-hot key vector, already synchronised to clock.
REQ-008 valor  output  VALOR_W  registered index of last accepted note.
REQ-009 nota_valida  output  1  high while an accepted note is held.
REQ-010 evento  output  1  one-cycle pulse on each accepted press.
REQ-011 erro  output  1  high while in ERRO state.

Function
REQ-012 States SHALL be OCIOSO, ESTABILIZA, PRESSIONADO, ERRO; all outputs registered.
REQ-013 nota classification per sample: ZERO (no bit), UNICA (exactly one bit, index i), MULTI (two or more bits).
REQ-014 OCIOSO: ZERO -> stay; UNICA -> ESTABILIZA, candidate=i, cnt=1; MULTI -> ERRO.
REQ-015 ESTABILIZA: same UNICA i and cnt<STABLE_CYCLES-1 -> cnt+1; same i and cnt==STABLE_CYCLES-1 -> PRESSIONADO; different UNICA j -> restart, candidate=j, cnt=1; ZERO -> OCIOSO; MULTI -> ERRO.
REQ-016 STABLE_CYCLES=1: OCIOSO on UNICA SHALL go directly to PRESSIONADO, bypassing ESTABILIZA.
REQ-017 On entry to PRESSIONADO: valor<=candidate and evento=1 for exactly one cycle; nota_valida=1 for every cycle in PRESSIONADO.
REQ-018 Latency: nota stable from before sampling edge 1 -> evento and nota_valida high in the cycle after edge STABLE_CYCLES.
REQ-019 PRESSIONADO: same i -> stay, no further evento; ZERO -> OCIOSO, valor retained; any other non-zero -> ERRO.
REQ-020 ERRO: erro=1, nota_valida=0; exit to OCIOSO only on a ZERO sample; valor retained.
REQ-021 enable low (synchronous): next state OCIOSO, cnt=0, valor=0, evento/nota_valida/erro=0; enable overrides all transitions in the same edge.
REQ-022 cnt SHALL be 8 bits and never wrap; it saturates at STABLE_CYCLES-1.

Reset
REQ-023 reset low asynchronously forces OCIOSO, cnt=0, candidate=0, valor=0, nota_valida=0, evento=0, erro=0.
REQ-024 Reset asserted mid-ESTABILIZA or mid-PRESSIONADO SHALL drop any pending evento; first evento after release requires a full STABLE_CYCLES count.

Configuration
REQ-025 Macro NOTA_PRIORIDADE_EN defined: MULTI samples are classified as UNICA with index = lowest set bit; ERRO unreachable; erro tied 0.
REQ-026 Macro undefined: MULTI handling per REQ-014/015/019 (enter ERRO).

Structure
REQ-027 Package nota_pkg SHALL hold the state enumeration, NUM_NOTAS default and STABLE_CYCLES default.
REQ-028 Combinational sub-module codificador_prioridade_nota (nota -> index, is_zero, is_multi) SHALL be instantiated once; the macro only affects how is_multi is used.

Verification
REQ-029 Defaults, nota=0x004 held 4 edges -> evento single pulse after edge 4, valor=2, nota_valida=1.
REQ-030 nota=0x010 for 2 edges then 0x020 held 4 -> exactly one evento, valor=5; no evento for 4.
REQ-031 nota=0x003 (macro undefined) -> erro=1 next cycle; nota=0 one edge -> erro=0, state OCIOSO.
REQ-032 nota=0x003 with NOTA_PRIORIDADE_EN held 4 edges -> evento, valor=0, erro never 1.
REQ-033 nota=0x800 pressed, evento seen, enable dropped 1 cycle -> valor=0, nota_valida=0; re-enabled with nota held -> new evento after 4 edges, valor=11.
REQ-034 reset pulsed low at cnt=2 -> all outputs 0 immediately; after release nota=0x001 -> evento exactly 4 edges later.

Source files
------------

// File: rtl/nota_pkg.sv
// nota_pkg: shared state encoding and parameter defaults for the note event encoder.
package nota_pkg;
    typedef enum logic [1:0] {OCIOSO, ESTABILIZA, PRESSIONADO, ERRO} estado_t;
    localparam int NUM_NOTAS_DEF     = 12;
    localparam int STABLE_CYCLES_DEF = 4;
endpackage

// File: rtl/codificador_prioridade_nota.sv
// codificador_prioridade_nota: one-hot note vector to lowest-set index plus zero/multi flags.
module codificador_prioridade_nota #(
    parameter int NUM_NOTAS = 12,
    parameter int VALOR_W   = 4
) (
    input  logic [NUM_NOTAS-1:0] nota,
    output logic [VALOR_W-1:0]   index,
    output logic                 is_zero,
    output logic                 is_multi
);
    always_comb begin
        index = '0;
        for (int k = NUM_NOTAS - 1; k >= 0; k--)
            if (nota[k]) index = VALOR_W'(k);
    end
    assign is_zero  = nota == '0;
    assign is_multi = (nota & (nota - NUM_NOTAS'(1))) != '0;
endmodule

// File: rtl/codificador_nota_evento.sv
// codificador_nota_evento: debounced one-hot key encoder with press event and error state.
// Define NOTA_PRIORIDADE_EN to resolve multi-key samples to the lowest key instead of erroring.
module codificador_nota_evento
    import nota_pkg::*;
#(
    parameter int NUM_NOTAS     = NUM_NOTAS_DEF,
    parameter int VALOR_W       = $clog2(NUM_NOTAS),
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_NOTAS-1:0] nota,
    output logic [VALOR_W-1:0]   valor,
    output logic                 nota_valida,
    output logic                 evento,
    output logic                 erro
);
`ifdef NOTA_PRIORIDADE_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    estado_t              state;
    logic [7:0]           cnt;
    logic [VALOR_W-1:0]   cand;
    logic [VALOR_W-1:0]   idx;
    logic                 is_zero;
    logic                 is_multi;
    logic                 multi;
    logic                 unica;
    logic                 erro_q;

    codificador_prioridade_nota #(.NUM_NOTAS(NUM_NOTAS), .VALOR_W(VALOR_W)) u_prio (
        .nota     (nota),
        .index    (idx),
        .is_zero  (is_zero),
        .is_multi (is_multi)
    );

    assign multi = PRIO ? 1'b0 : is_multi;
    assign unica = !is_zero && !multi;
    assign erro  = PRIO ? 1'b0 : erro_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OCIOSO;
            cnt         <= '0;
            cand        <= '0;
            valor       <= '0;
            nota_valida <= 1'b0;
            evento      <= 1'b0;
            erro_q      <= 1'b0;
        end else if (!enable) begin
            state       <= OCIOSO;
            cnt         <= '0;
            cand        <= '0;
            valor       <= '0;
            nota_valida <= 1'b0;
            evento      <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            evento <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (multi) begin
                        state  <= ERRO;
                        erro_q <= 1'b1;
                    end else if (unica) begin
                        cand <= idx;
                        if (CNT_MAX == '0) begin
                            state       <= PRESSIONADO;
                            valor       <= idx;
                            evento      <= 1'b1;
                            nota_valida <= 1'b1;
                        end else begin
                            state <= ESTABILIZA;
                            cnt   <= 8'd1;
                        end
                    end
                end
                ESTABILIZA: begin
                    if (multi) begin
                        state  <= ERRO;
                        erro_q <= 1'b1;
                        cnt    <= '0;
                    end else if (is_zero) begin
                        state <= OCIOSO;
                        cnt   <= '0;
                    end else if (idx != cand) begin
                        cand <= idx;
                        cnt  <= 8'd1;
                    end else if (cnt >= CNT_MAX) begin
                        state       <= PRESSIONADO;
                        valor       <= cand;
                        evento      <= 1'b1;
                        nota_valida <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PRESSIONADO: begin
                    if (is_zero) begin
                        state       <= OCIOSO;
                        nota_valida <= 1'b0;
                        cnt         <= '0;
                    end else if (multi || idx != cand) begin
                        // without an error state a new key simply starts a fresh debounce
                        if (PRIO) begin
                            cand <= idx;
                            if (CNT_MAX == '0) begin
                                valor  <= idx;
                                evento <= 1'b1;
                            end else begin
                                state       <= ESTABILIZA;
                                cnt         <= 8'd1;
                                nota_valida <= 1'b0;
                            end
                        end else begin
                            state       <= ERRO;
                            erro_q      <= 1'b1;
                            nota_valida <= 1'b0;
                            cnt         <= '0;
                        end
                    end
                end
                ERRO: begin
                    if (is_zero) begin
                        state  <= OCIOSO;
                        erro_q <= 1'b0;
                    end
                end
                default: state <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_codificador_nota_evento.sv
// tb_codificador_nota_evento: scoreboard bench for the note event encoder (default parameters).
module tb_codificador_nota_evento;
    typedef struct packed {
        logic       ev;
        logic       nv;
        logic       er;
        logic [3:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [11:0] nota = '0;
    logic [3:0]  valor;
    logic        nota_valida;
    logic        evento;
    logic        erro;
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [3:0]  vl;

    codificador_nota_evento dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .nota        (nota),
        .valor       (valor),
        .nota_valida (nota_valida),
        .evento      (evento),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic e, input logic [11:0] n, input logic ev, input logic nv,
                        input logic er, input logic [3:0] v);
        exp_t x;
        enable = e;
        nota = n;
        sb.push_back('{ev: ev, nv: nv, er: er, val: v});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            x = sb.pop_front();
            chk("evento", 8'(evento), 8'(x.ev));
            chk("nota_valida", 8'(nota_valida), 8'(x.nv));
            chk("erro", 8'(erro), 8'(x.er));
            chk("valor", 8'(valor), 8'(x.val));
        end
    endtask

    // holds n for k edges: no event until the last edge, which must fire with valor=vn
    task automatic press(input logic [11:0] n, input int k, input logic [3:0] vp, input logic [3:0] vn);
        for (int i = 1; i < k; i++) step(1'b1, n, 1'b0, 1'b0, 1'b0, vp);
        step(1'b1, n, 1'b1, 1'b1, 1'b0, vn);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valor", 8'(valor), 8'd0);
        chk("rst_nota_valida", 8'(nota_valida), 8'd0);
        chk("rst_evento", 8'(evento), 8'd0);
        chk("rst_erro", 8'(erro), 8'd0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #12;
        chk("init_valor", 8'(valor), 8'd0);
        chk("init_nota_valida", 8'(nota_valida), 8'd0);
        chk("init_evento", 8'(evento), 8'd0);
        chk("init_erro", 8'(erro), 8'd0);
        rst_n = 1'b1;
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0);
        press(12'h004, 4, 4'd0, 4'd2);
        step(1'b1, 12'h004, 1'b0, 1'b1, 1'b0, 4'd2);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 4'd2);
        press(12'h020, 4, 4'd2, 4'd5);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd5);
`ifdef NOTA_PRIORIDADE_EN
        press(12'h003, 4, 4'd5, 4'd0);
        step(1'b1, 12'h003, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0);
        vl = 4'd0;
`else
        step(1'b1, 12'h003, 1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd5);
        press(12'h002, 4, 4'd5, 4'd1);
        step(1'b1, 12'h004, 1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b1, 12'h004, 1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd1);
        vl = 4'd1;
`endif
        press(12'h800, 4, vl, 4'd11);
        step(1'b0, 12'h800, 1'b0, 1'b0, 1'b0, 4'd0);
        press(12'h800, 4, 4'd0, 4'd11);
        step(1'b1, 12'h800, 1'b0, 1'b1, 1'b0, 4'd11);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd11);
        press(12'h080, 4, 4'd11, 4'd7);
        step(1'b1, 12'h080, 1'b0, 1'b1, 1'b0, 4'd7);
        pulse_reset();
        step(1'b1, 12'h001, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 12'h001, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse_reset();
        press(12'h001, 4, 4'd0, 4'd0);
        step(1'b1, 12'h001, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
